// File: rtl/tdc_result_buffer_pkg.sv
// tdc_result_buffer_pkg: shared field widths, slice offsets, result record and interval helper
package tdc_result_buffer_pkg;
  localparam int NUM_DECODE = 8;
  localparam int DIG_OUT = 3 * NUM_DECODE;
  localparam int RES_W = 2 * NUM_DECODE + 1;
  localparam int SEQ_W = 4;
  localparam int OVF_W = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int DOUT_W = SEQ_W + RES_W;
  localparam int COARSE_LSB = 2 * NUM_DECODE;
  localparam int START_LSB = NUM_DECODE;
  localparam int FALL_LSB = 0;
  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [RES_W-1:0] result;
  } result_t;
  function automatic logic [RES_W-1:0] tdc_interval(input logic [NUM_DECODE-1:0] coarse, start, fall);
    return {1'b0, coarse, start} - {{(NUM_DECODE+1){1'b0}}, fall};
  endfunction
endpackage

// File: rtl/tdc_result_buffer_if.sv
// tdc_result_buffer_if: enable/din/din_valid in, dout/dout_valid/dout_ready handshake out, full and overflow_cnt status
interface tdc_result_buffer_if
  import tdc_result_buffer_pkg::*;
;
  logic enable;
  logic [DIG_OUT-1:0] din;
  logic din_valid;
  logic [DOUT_W-1:0] dout;
  logic dout_valid;
  logic dout_ready;
  logic full;
  logic [OVF_W-1:0] overflow_cnt;
  modport master(output enable, din, din_valid, dout_ready, input dout, dout_valid, full, overflow_cnt);
  modport slave(input enable, din, din_valid, dout_ready, output dout, dout_valid, full, overflow_cnt);
endinterface

// File: rtl/tdc_result_buffer_fifo.sv
// tdc_sync_fifo: generic FWFT sync FIFO; wr_en/din in, rd_en/dout out (dout = head), empty/full flags
module tdc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_rd, do_wr;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_wr) mem[wr_ptr] <= din;
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
    end
  end
endmodule

// File: rtl/tdc_result_buffer.sv
// tdc_result_buffer: clk/rst plus bus (din in, {seq,interval} FWFT dout out, full, saturating overflow_cnt)
module tdc_result_buffer
  import tdc_result_buffer_pkg::*;
(
  input logic clk,
  input logic rst,
  tdc_result_buffer_if.slave bus
);
  logic [SEQ_W-1:0] seq;
  logic s1_valid, s2_valid;
  logic [NUM_DECODE-1:0] s1_coarse, s1_start, s1_fall;
  logic [SEQ_W-1:0] s1_seq;
  result_t s2;
  logic accept, pop, drop, empty;
  assign accept = bus.din_valid && bus.enable;
  assign pop = bus.dout_valid && bus.dout_ready;
  assign drop = s2_valid && bus.full && !pop;
  assign bus.dout_valid = !empty;
  always_ff @(posedge clk) begin
    if (rst) begin
      seq <= '0;
      s1_valid <= 1'b0;
      s1_coarse <= '0;
      s1_start <= '0;
      s1_fall <= '0;
      s1_seq <= '0;
      s2_valid <= 1'b0;
      s2 <= '0;
      bus.overflow_cnt <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_coarse <= bus.din[COARSE_LSB +: NUM_DECODE];
        s1_start <= bus.din[START_LSB +: NUM_DECODE];
        s1_fall <= bus.din[FALL_LSB +: NUM_DECODE];
        s1_seq <= seq;
        seq <= seq + SEQ_W'(1);
      end
      s2_valid <= s1_valid;
      s2 <= '{seq: s1_seq, result: tdc_interval(s1_coarse, s1_start, s1_fall)};
      if (drop && bus.overflow_cnt != '1) bus.overflow_cnt <= bus.overflow_cnt + OVF_W'(1);
    end
  end
  tdc_sync_fifo #(.WIDTH(DOUT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr_en(s2_valid),
    .din(s2),
    .rd_en(pop),
    .dout(bus.dout),
    .empty(empty),
    .full(bus.full)
  );
endmodule

// File: tb/tb_tdc_result_buffer.sv
// tb_tdc_result_buffer: directed stimulus with a queue scoreboard checked by a decoupled output monitor
module tb_tdc_result_buffer;
  import tdc_result_buffer_pkg::*;
  logic clk = 1'b0;
  logic rst;
  int passed = 0;
  int total = 0;
  logic [DOUT_W-1:0] exp_q[$];
  logic [SEQ_W-1:0] seq_m;
  tdc_result_buffer_if bus();
  tdc_result_buffer dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (!rst && bus.dout_valid && bus.dout_ready) begin
      total++;
      if (exp_q.size() == 0) $display("FAIL unexpected_output: got %h, required no output", bus.dout);
      else begin
        logic [DOUT_W-1:0] e;
        e = exp_q.pop_front();
        if (bus.dout === e) passed++;
        else $display("FAIL scoreboard: got seq=%0d res=%h, required seq=%0d res=%h", bus.dout[DOUT_W-1 -: SEQ_W], bus.dout[RES_W-1:0], e[DOUT_W-1 -: SEQ_W], e[RES_W-1:0]);
      end
    end
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask
  task automatic send(input logic [7:0] c, input logic [7:0] s, input logic [7:0] f, input logic [RES_W-1:0] res, input bit keep);
    bus.din = {c, s, f};
    bus.din_valid = 1'b1;
    @(posedge clk);
    #1 bus.din_valid = 1'b0;
    if (keep) exp_q.push_back({seq_m, res});
    seq_m++;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    seq_m = '0;
  endtask
  task automatic drain();
    int n;
    bus.dout_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || bus.dout_valid) && n < 200) begin
      @(posedge clk);
      #2 n++;
    end
    if (n >= 200) begin
      total++;
      $display("FAIL drain_timeout: got %0d entries pending, required 0", exp_q.size());
    end
  endtask
  initial begin
    rst = 1'b1;
    seq_m = '0;
    bus.enable = 1'b1;
    bus.din = '0;
    bus.din_valid = 1'b0;
    bus.dout_ready = 1'b1;
    do_reset();
    check("reset_dout_valid", 32'(bus.dout_valid), 0);
    check("reset_full", 32'(bus.full), 0);
    check("reset_ovf", 32'(bus.overflow_cnt), 0);
    check("reset_dout", 32'(bus.dout), 0);
    bus.dout_ready = 1'b0;
    send(8'h03, 8'h10, 8'h05, 17'h0030B, 1'b1);
    @(posedge clk);
    #1 check("latency_k1", 32'(bus.dout_valid), 0);
    @(posedge clk);
    #1 check("latency_k2", 32'(bus.dout_valid), 1);
    check("single_dout", 32'(bus.dout), 32'({4'd0, 17'h0030B}));
    drain();
    send(8'h00, 8'h02, 8'h09, 17'h1FFF9, 1'b1);
    send(8'hFF, 8'hFF, 8'h00, 17'h0FFFF, 1'b1);
    send(8'h00, 8'h00, 8'hFF, 17'h1FF01, 1'b1);
    send(8'h12, 8'h34, 8'h34, 17'h01200, 1'b1);
    drain();
    do_reset();
    bus.dout_ready = 1'b0;
    for (int i = 0; i < 17; i++) send(8'(i), 8'(3 * i), 8'(i), 17'(i * 256 + 2 * i), i < 16);
    repeat (3) @(posedge clk);
    #1 check("ovf_full", 32'(bus.full), 1);
    check("ovf_cnt1", 32'(bus.overflow_cnt), 1);
    drain();
    check("ovf_drained_full", 32'(bus.full), 0);
    check("seq_after_drop", 32'(seq_m), 1);
    send(8'h01, 8'h00, 8'h00, 17'h00100, 1'b1);
    drain();
    do_reset();
    bus.dout_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(8'h20, 8'(i), 8'h00, 17'(32'h2000 + i), 1'b1);
    repeat (3) @(posedge clk);
    #1 check("fill_full", 32'(bus.full), 1);
    send(8'h40, 8'h00, 8'h01, 17'h03FFF, 1'b1);
    @(posedge clk);
    #1 bus.dout_ready = 1'b1;
    @(posedge clk);
    #1 bus.dout_ready = 1'b0;
    check("pop_write_full", 32'(bus.full), 1);
    check("pop_write_ovf", 32'(bus.overflow_cnt), 0);
    drain();
    check("pop_write_ovf_after", 32'(bus.overflow_cnt), 0);
    send(8'h05, 8'h05, 8'h05, 17'h00500, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    seq_m = '0;
    check("midrst_valid", 32'(bus.dout_valid), 0);
    check("midrst_dout", 32'(bus.dout), 0);
    repeat (4) @(posedge clk);
    #1 check("midrst_lost", 32'(bus.dout_valid), 0);
    send(8'h07, 8'h01, 8'h02, 17'h006FF, 1'b1);
    drain();
    bus.enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.din = 24'hABCDEF;
      bus.din_valid = 1'b1;
      @(posedge clk);
      #1 bus.din_valid = 1'b0;
    end
    repeat (5) @(posedge clk);
    #1 check("enable_low", 32'(bus.dout_valid), 0);
    bus.enable = 1'b1;
    send(8'h00, 8'h09, 8'h02, 17'h00007, 1'b1);
    drain();
    do_reset();
    bus.dout_ready = 1'b0;
    for (int i = 0; i < 316; i++) send(8'h01, 8'(i), 8'h00, 17'(256 + (i & 255)), i < 16);
    repeat (3) @(posedge clk);
    #1 check("sat_cnt", 32'(bus.overflow_cnt), 255);
    check("sat_full", 32'(bus.full), 1);
    drain();
    check("sat_hold", 32'(bus.overflow_cnt), 255);
    do_reset();
    check("final_ovf", 32'(bus.overflow_cnt), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
